d_instr_buffer: RTL and testbench
=================================

# d_instr_buffer

Decode-side receiver for the fetch-to-decode interface. It accepts `{pc, instr}` beats from the fetch stage under a valid/ready handshake and holds them in a small FIFO so that fetch can run ahead of stalls. It drains entries in order to the A stage together with fully decoded RV32I fields. A branch redirect (`br_en`) flushes every buffered entry.

## Interface
Parameters:
- `XLEN`, 32: width of PC and instruction.
- `DEPTH`, 2: FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = in reset).
- `f_valid`  in  1  fetch presents a beat.
- `f_pc_o`  in  XLEN  PC of the presented instruction.
- `instr`  in  XLEN  presented instruction word.
- `d_ready`  out  1  buffer can accept a beat this cycle.
- `br_en`  in  1  redirect/flush request.
- `a_ready`  in  1  A stage accepts the head entry.
- `d_valid`  out  1  head entry is valid.
- `d_pc`  out  XLEN  head PC.
- `d_instr`  out  XLEN  head instruction.
- `d_opcode`  out  7  `instr[6:0]`.
- `d_rd`, `d_rs1`, `d_rs2`  out  5 each  `instr[11:7]`, `instr[19:15]`, `instr[24:20]`.
- `d_funct3`  out  3  `instr[14:12]`.
- `d_funct7`  out  7  `instr[31:25]`.
- `d_imm`  out  XLEN  sign-extended immediate.
- `d_illegal`  out  1  head opcode is not a recognised RV32I major opcode.

## Operation
- Storage: `DEPTH`-entry circular FIFO of `{pc, instr}`, with read pointer, write pointer (`log2(DEPTH)` bits, wrapping) and an occupancy `count` (`log2(DEPTH)+1` bits).
- `d_ready = reset && (count < DEPTH) && !br_en`.
- Push happens when `f_valid && d_ready`. Pop happens when `d_valid && a_ready && !br_en`.
- Push and pop in the same cycle: both take effect and `count` is unchanged. When full, `d_ready` is 0 even if a pop happens that cycle. There is no bypass.
- `d_valid = (count != 0)`. All `d_*` outputs decode the head entry combinationally from registered storage.
- Flush: when `br_en` = 1 at a clock edge, `count` goes to 0, pointers reset to 0, and no push or pop occurs in that cycle. Stored data need not be cleared.
- Immediate decode by opcode:
  - I-type (0000011, 0010011, 1100111, 1110011): `sext(instr[31:20])`.
  - S-type (0100011): `sext({instr[31:25],instr[11:7]})`.
  - B-type (1100011): `sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})`.
  - U-type (0110111, 0010111): `{instr[31:12],12'b0}`.
  - J-type (1101111): `sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})`.
  - R-type (0110011), FENCE (0001111): 0.
- `d_illegal` = 1 for any opcode not listed above. It is only meaningful while `d_valid` = 1.
- When `d_valid` = 0, the decoded outputs are don't-care. The bench checks them only when `d_valid` = 1.

## Timing
- During reset: `count` = 0, pointers = 0, `d_ready` = 0, `d_valid` = 0, and all data outputs are 0 because storage is cleared on reset.
- Deassertion of reset is synchronised by the system. `d_ready` = 1 in the first cycle after reset deasserts.
- Latency: a beat pushed at edge N appears on `d_valid`/`d_*` after edge N, so it can be popped at edge N+1. Minimum one cycle from fetch to A.
- Throughput: one beat per cycle in steady state when `a_ready` is held at 1.
- Stall: with `a_ready` = 0, `d_ready` drops immediately after the `DEPTH`-th push. It reasserts in the cycle after the first pop.
- Reset asserted mid-operation: all state clears immediately (asynchronously). In-flight entries are lost.
- `br_en` concurrent with `f_valid`: the incoming beat is dropped. Fetch must resend from the redirect target.

## Test plan
- Reset then single beat: `f_pc_o` = 0x100, `instr` = 0x00500093 (addi x1,x0,5). Next cycle: `d_valid` = 1, `d_opcode` = 0x13, `d_rd` = 1, `d_rs1` = 0, `d_imm` = 5, `d_illegal` = 0.
- Immediate formats:
  - 0xFE208EE3 (beq x1,x2,-4) → `d_imm` = 0xFFFFFFFC, `d_rs1` = 1, `d_rs2` = 2.
  - 0x0020A423 (sw x2,8(x1)) → `d_imm` = 8.
  - 0x123452B7 (lui x5) → `d_imm` = 0x12345000.
  - 0xFFFFFFFF → `d_illegal` = 1.
- Backpressure: hold `a_ready` = 0 and stream PCs 0x0, 0x4, 0x8. After 2 pushes, `d_ready` = 0 and 0x8 is held at fetch. Release `a_ready`: outputs 0x0, 0x4, 0x8 in order, with no loss or duplication.
- Simultaneous push/pop at `count` = 1 with `a_ready` = 1: `count` stays 1. Sustain 8 beats at one per cycle; the pointers wrap correctly.
- Flush: fill to 2 entries, then pulse `br_en` with `f_valid` = 1 (PC 0x40). Next cycle `d_valid` = 0 and 0x40 is absent. The following push of 0x200 appears as the head.
- Reset asserted with 2 entries buffered: `d_valid` and `d_ready` go to 0 immediately. After release, `d_valid` = 0 and `d_ready` = 1.

Source files
------------

// File: rtl/d_instr_buffer.sv
// Fetch-to-decode receive buffer: a small in-order FIFO of {pc, instr} beats
// with a combinational RV32I field/immediate decode of the head entry.
module d_instr_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     f_valid,
  input  logic [XLEN-1:0]          f_pc_o,
  input  logic [XLEN-1:0]          instr,
  output logic                     d_ready,
  input  logic                     br_en,
  input  logic                     a_ready,
  output logic                     d_valid,
  output logic [XLEN-1:0]          d_pc,
  output logic [XLEN-1:0]          d_instr,
  output logic [6:0]               d_opcode,
  output logic [4:0]               d_rd,
  output logic [4:0]               d_rs1,
  output logic [4:0]               d_rs2,
  output logic [2:0]               d_funct3,
  output logic [6:0]               d_funct7,
  output logic [XLEN-1:0]          d_imm,
  output logic                     d_illegal,
  output logic [$clog2(DEPTH):0]   dbg_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;

  // Handshake: a beat transfers on a rising edge where valid and ready are both
  // high. Ready never depends on the same-cycle pop (no bypass), and br_en
  // blocks both sides so a flush cycle moves nothing.
  assign d_ready = reset && (count != FULL) && !br_en;
  assign d_valid = (count != '0);
  assign push    = f_valid && d_ready;
  assign pop     = d_valid && a_ready && !br_en;
  assign dbg_count = count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (br_en) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= f_pc_o;
        instr_mem[wr_ptr] <= instr;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  logic [31:0] h;
  logic [31:0] imm32;
  logic        illegal;

  assign d_pc     = pc_mem[rd_ptr];
  assign d_instr  = instr_mem[rd_ptr];
  assign h        = d_instr[31:0];
  assign d_opcode = h[6:0];
  assign d_rd     = h[11:7];
  assign d_funct3 = h[14:12];
  assign d_rs1    = h[19:15];
  assign d_rs2    = h[24:20];
  assign d_funct7 = h[31:25];

  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (h[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
        imm32 = {{20{h[31]}}, h[31:20]};
      7'b0100011:
        imm32 = {{20{h[31]}}, h[31:25], h[11:7]};
      7'b1100011:
        imm32 = {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        imm32 = {h[31:12], 12'b0};
      7'b1101111:
        imm32 = {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};
      7'b0110011, 7'b0001111:
        imm32 = '0;
      default:
        illegal = 1'b1;
    endcase
  end

  // Immediates are built at 32 bits and sign-extended to XLEN.
  assign d_imm     = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
  assign d_illegal = illegal;

endmodule

// File: tb/tb_d_instr_buffer.sv
// Directed bench for d_instr_buffer: reset, decode formats, backpressure,
// streaming with pointer wrap, flush and asynchronous mid-run reset.
module tb_d_instr_buffer;

  logic        clock;
  logic        reset;
  logic        f_valid;
  logic [31:0] f_pc_o;
  logic [31:0] instr;
  logic        d_ready;
  logic        br_en;
  logic        a_ready;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic [6:0]  d_opcode;
  logic [4:0]  d_rd;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [2:0]  d_funct3;
  logic [6:0]  d_funct7;
  logic [31:0] d_imm;
  logic        d_illegal;
  logic [1:0]  dbg_count;

  int tests_run = 0;
  int fails     = 0;

  d_instr_buffer #(.XLEN(32), .DEPTH(2)) dut (
    .clock(clock), .reset(reset), .f_valid(f_valid), .f_pc_o(f_pc_o),
    .instr(instr), .d_ready(d_ready), .br_en(br_en), .a_ready(a_ready),
    .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr), .d_opcode(d_opcode),
    .d_rd(d_rd), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_funct3(d_funct3),
    .d_funct7(d_funct7), .d_imm(d_imm), .d_illegal(d_illegal),
    .dbg_count(dbg_count)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] ins);
    f_valid = 1'b1;
    f_pc_o  = pc;
    instr   = ins;
    step();
    f_valid = 1'b0;
    #1;
  endtask

  task automatic pop_one();
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests_run++; if (d_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %0b exp 0", d_ready); end
    tests_run++; if (d_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b exp 0", d_valid); end
    tests_run++; if (d_pc !== 32'h0) begin fails++; $display("FAIL rst_pc got %h exp 0", d_pc); end
    tests_run++; if (d_instr !== 32'h0) begin fails++; $display("FAIL rst_instr got %h exp 0", d_instr); end
    tests_run++; if (dbg_count !== 2'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", dbg_count); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    tests_run++; if (d_ready !== 1'b1) begin fails++; $display("FAIL rel_ready got %0b exp 1", d_ready); end
    tests_run++; if (d_valid !== 1'b0) begin fails++; $display("FAIL rel_valid got %0b exp 0", d_valid); end
  endtask

  task automatic test_single();
    a_ready = 1'b0;
    push_one(32'h100, 32'h00500093);
    tests_run++; if (d_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %0b exp 1", d_valid); end
    tests_run++; if (d_pc !== 32'h100) begin fails++; $display("FAIL single_pc got %h exp 00000100", d_pc); end
    tests_run++; if (d_opcode !== 7'h13) begin fails++; $display("FAIL single_opcode got %h exp 13", d_opcode); end
    tests_run++; if (d_rd !== 5'd1) begin fails++; $display("FAIL single_rd got %0d exp 1", d_rd); end
    tests_run++; if (d_rs1 !== 5'd0) begin fails++; $display("FAIL single_rs1 got %0d exp 0", d_rs1); end
    tests_run++; if (d_imm !== 32'd5) begin fails++; $display("FAIL single_imm got %h exp 00000005", d_imm); end
    tests_run++; if (d_illegal !== 1'b0) begin fails++; $display("FAIL single_illegal got %0b exp 0", d_illegal); end
    pop_one();
    tests_run++; if (d_valid !== 1'b0) begin fails++; $display("FAIL single_drain got %0b exp 0", d_valid); end
  endtask

  task automatic test_imm_formats();
    logic [31:0] vec_instr [8];
    logic [31:0] vec_imm   [8];
    logic        vec_ill   [8];
    vec_instr[0] = 32'hFE208EE3; vec_imm[0] = 32'hFFFFFFFC; vec_ill[0] = 1'b0;  // beq x1,x2,-4
    vec_instr[1] = 32'h0020A423; vec_imm[1] = 32'h00000008; vec_ill[1] = 1'b0;  // sw x2,8(x1)
    vec_instr[2] = 32'h123452B7; vec_imm[2] = 32'h12345000; vec_ill[2] = 1'b0;  // lui x5
    vec_instr[3] = 32'hFFFFFFFF; vec_imm[3] = 32'h00000000; vec_ill[3] = 1'b1;
    vec_instr[4] = 32'hFFF00093; vec_imm[4] = 32'hFFFFFFFF; vec_ill[4] = 1'b0;  // addi x1,x0,-1
    vec_instr[5] = 32'h00001097; vec_imm[5] = 32'h00001000; vec_ill[5] = 1'b0;  // auipc x1,1
    vec_instr[6] = 32'h008000EF; vec_imm[6] = 32'h00000008; vec_ill[6] = 1'b0;  // jal x1,8
    vec_instr[7] = 32'h002081B3; vec_imm[7] = 32'h00000000; vec_ill[7] = 1'b0;  // add x3,x1,x2
    a_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_one(32'h300 + 32'(i * 4), vec_instr[i]);
      tests_run++;
      if (d_illegal !== vec_ill[i]) begin
        fails++; $display("FAIL imm_illegal[%0d] got %0b exp %0b", i, d_illegal, vec_ill[i]);
      end
      if (!vec_ill[i]) begin
        tests_run++;
        if (d_imm !== vec_imm[i]) begin
          fails++; $display("FAIL imm_value[%0d] got %h exp %h", i, d_imm, vec_imm[i]);
        end
      end
      pop_one();
    end
    push_one(32'h400, 32'hFE208EE3);
    tests_run++; if (d_rs1 !== 5'd1) begin fails++; $display("FAIL beq_rs1 got %0d exp 1", d_rs1); end
    tests_run++; if (d_rs2 !== 5'd2) begin fails++; $display("FAIL beq_rs2 got %0d exp 2", d_rs2); end
    tests_run++; if (d_funct7 !== 7'h7F) begin fails++; $display("FAIL beq_funct7 got %h exp 7f", d_funct7); end
    tests_run++; if (d_funct3 !== 3'd0) begin fails++; $display("FAIL beq_funct3 got %0d exp 0", d_funct3); end
    pop_one();
  endtask

  task automatic test_backpressure();
    a_ready = 1'b0;
    f_valid = 1'b1; f_pc_o = 32'h0; instr = 32'h00000013;
    step();
    f_pc_o = 32'h4;
    tests_run++; if (d_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got %0b exp 1", d_ready); end
    step();
    f_pc_o = 32'h8;
    #1;
    tests_run++; if (d_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready got %0b exp 0", d_ready); end
    tests_run++; if (dbg_count !== 2'd2) begin fails++; $display("FAIL bp_full_count got %0d exp 2", dbg_count); end
    step();
    tests_run++; if (dbg_count !== 2'd2) begin fails++; $display("FAIL bp_hold_count got %0d exp 2", dbg_count); end
    tests_run++; if (d_pc !== 32'h0) begin fails++; $display("FAIL bp_hold_pc got %h exp 00000000", d_pc); end
    a_ready = 1'b1;
    #1;
    tests_run++; if (d_ready !== 1'b0) begin fails++; $display("FAIL bp_full_pop_ready got %0b exp 0", d_ready); end
    step();
    tests_run++; if (d_ready !== 1'b1) begin fails++; $display("FAIL bp_reassert got %0b exp 1", d_ready); end
    tests_run++; if (d_pc !== 32'h4) begin fails++; $display("FAIL bp_out1 got %h exp 00000004", d_pc); end
    step();
    f_valid = 1'b0;
    #1;
    tests_run++; if (d_pc !== 32'h8) begin fails++; $display("FAIL bp_out2 got %h exp 00000008", d_pc); end
    tests_run++; if (dbg_count !== 2'd1) begin fails++; $display("FAIL bp_out2_count got %0d exp 1", dbg_count); end
    step();
    a_ready = 1'b0;
    tests_run++; if (d_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %0b exp 0", d_valid); end
  endtask

  task automatic test_back_to_back();
    a_ready = 1'b1;
    push_one(32'h1000, 32'h00000013);
    for (int i = 1; i <= 8; i++) begin
      f_valid = 1'b1;
      f_pc_o  = 32'h1000 + 32'(i * 4);
      instr   = 32'h00000013 | (32'(i) << 20);
      #1;
      tests_run++;
      if (d_pc !== 32'h1000 + 32'((i - 1) * 4) || dbg_count !== 2'd1 || d_valid !== 1'b1) begin
        fails++; $display("FAIL b2b[%0d] got pc %h cnt %0d exp pc %h cnt 1", i, d_pc, dbg_count,
                          32'h1000 + 32'((i - 1) * 4));
      end
      tests_run++;
      if (d_imm !== 32'(i - 1)) begin
        fails++; $display("FAIL b2b_imm[%0d] got %h exp %h", i, d_imm, 32'(i - 1));
      end
      step();
    end
    f_valid = 1'b0;
    #1;
    tests_run++; if (d_pc !== 32'h1020) begin fails++; $display("FAIL b2b_last got %h exp 00001020", d_pc); end
    step();
    a_ready = 1'b0;
    tests_run++; if (d_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %0b exp 0", d_valid); end
  endtask

  task automatic test_flush();
    a_ready = 1'b0;
    push_one(32'h10, 32'h00000013);
    push_one(32'h14, 32'h00000013);
    br_en = 1'b1; f_valid = 1'b1; f_pc_o = 32'h40;
    #1;
    tests_run++; if (d_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got %0b exp 0", d_ready); end
    step();
    br_en = 1'b0; f_valid = 1'b0;
    #1;
    tests_run++; if (d_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %0b exp 0", d_valid); end
    tests_run++; if (dbg_count !== 2'd0) begin fails++; $display("FAIL flush_count got %0d exp 0", dbg_count); end
    tests_run++; if (d_ready !== 1'b1) begin fails++; $display("FAIL flush_after_ready got %0b exp 1", d_ready); end
    push_one(32'h200, 32'h00000013);
    tests_run++; if (d_pc !== 32'h200) begin fails++; $display("FAIL flush_head got %h exp 00000200", d_pc); end
    tests_run++; if (dbg_count !== 2'd1) begin fails++; $display("FAIL flush_head_count got %0d exp 1", dbg_count); end
    pop_one();
    tests_run++; if (d_valid !== 1'b0) begin fails++; $display("FAIL flush_drain got %0b exp 0", d_valid); end
  endtask

  task automatic test_reset_mid();
    a_ready = 1'b0;
    push_one(32'h500, 32'h00500093);
    push_one(32'h504, 32'h00500093);
    reset = 1'b0;
    #1;
    tests_run++; if (d_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid got %0b exp 0", d_valid); end
    tests_run++; if (d_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready got %0b exp 0", d_ready); end
    tests_run++; if (d_pc !== 32'h0) begin fails++; $display("FAIL mid_rst_pc got %h exp 0", d_pc); end
    step();
    reset = 1'b1;
    #1;
    tests_run++; if (d_valid !== 1'b0) begin fails++; $display("FAIL mid_rel_valid got %0b exp 0", d_valid); end
    tests_run++; if (d_ready !== 1'b1) begin fails++; $display("FAIL mid_rel_ready got %0b exp 1", d_ready); end
    tests_run++; if (dbg_count !== 2'd0) begin fails++; $display("FAIL mid_rel_count got %0d exp 0", dbg_count); end
  endtask

  initial begin
    reset   = 1'b0;
    f_valid = 1'b0;
    f_pc_o  = '0;
    instr   = '0;
    br_en   = 1'b0;
    a_ready = 1'b0;
    test_reset();
    test_single();
    test_imm_formats();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
